wb_access_sequencer: RTL and testbench

WB_ACCESS_SEQUENCER -- requirements
Module: wb_access_sequencer

---
 rtl/wb_access_sequencer.sv | 176 +++++++++++++++++
 tb/tb_wb_access_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_access_sequencer.sv
// wb_access_sequencer
//   Bridges one Wishbone master onto NUM_TEAMS+2 slave slots, one transaction
//   at a time. The address is decoded to a one-hot slave strobe. The request
//   is latched and held on slv_* while the target is accessed. Its ack and read
//   data are returned on wbs_ack_o/wbs_dat_o. Decode errors and timeouts answer
//   the master with 32'hDEAD_BEEF and record a fault.
//
//   Ports
//     wb_clk_i, nrst            clock, async active-low reset
//     wbs_*_i / wbs_*_o         master side request / response
//     slv_*_o                   latched request and one-hot strobe to slaves
//     slv_ack_i, slv_dat_i      per-slot ack and read data (slot n at [32n+:32])
//     err_o                     one-cycle fault pulse in the response cycle
//     fault_cnt_o, fault_adr_o  saturating fault count, address of latest fault
module wb_access_sequencer #(
    parameter int NUM_TEAMS = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        nrst,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_we_i,
    input  logic [3:0]                  wbs_sel_i,
    input  logic [31:0]                 wbs_dat_i,
    input  logic [31:0]                 wbs_adr_i,
    output logic                        wbs_ack_o,
    output logic [31:0]                 wbs_dat_o,
    output logic [NUM_TEAMS+1:0]        slv_stb_o,
    output logic                        slv_cyc_o,
    output logic                        slv_we_o,
    output logic [3:0]                  slv_sel_o,
    output logic [31:0]                 slv_dat_o,
    output logic [31:0]                 slv_adr_o,
    input  logic [NUM_TEAMS+1:0]        slv_ack_i,
    input  logic [32*(NUM_TEAMS+2)-1:0] slv_dat_i,
    output logic                        err_o,
    output logic [7:0]                  fault_cnt_o,
    output logic [31:0]                 fault_adr_o
);
    localparam int NS = NUM_TEAMS + 2;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e          state_q;
    logic [7:0]      cnt_q;
    logic [NS-1:0]   stb_q;
    logic            cyc_q, we_q, ack_q, err_q;
    logic [3:0]      sel_q;
    logic [31:0]     dat_q, adr_q, rdat_q, fadr_q;
    logic [7:0]      fcnt_q;

    // Combinational decode of the incoming address into a one-hot slot strobe.
    logic [NS-1:0]   dec_stb_d;
    logic            dec_ok_d;

    always_comb begin
        dec_stb_d = '0;
        dec_ok_d  = 1'b0;
        if (wbs_adr_i[31:24] == 8'h30) begin
            if (wbs_adr_i[23:16] == 8'h00) begin
                dec_stb_d[0] = 1'b1;
                dec_ok_d     = 1'b1;
            end else if (wbs_adr_i[23:16] == 8'h01) begin
                dec_stb_d[1] = 1'b1;
                dec_ok_d     = 1'b1;
            end else begin
                for (int k = 1; k <= NUM_TEAMS; k++) begin
                    if (wbs_adr_i[23:16] == 8'(16 + k)) begin
                        dec_stb_d[1+k] = 1'b1;
                        dec_ok_d       = 1'b1;
                    end
                end
            end
        end
    end

    // Only the strobed slot may complete the access; other acks are masked off.
    logic            ack_hit;
    logic [31:0]     rd_mux;

    assign ack_hit = |(slv_ack_i & stb_q);

    always_comb begin
        rd_mux = '0;
        for (int n = 0; n < NS; n++) begin
            if (stb_q[n]) rd_mux = slv_dat_i[n*32 +: 32];
        end
    end

    always_ff @(posedge wb_clk_i or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stb_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            adr_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
            fadr_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wbs_stb_i && wbs_cyc_i) begin
                        we_q  <= wbs_we_i;
                        sel_q <= wbs_sel_i;
                        dat_q <= wbs_dat_i;
                        adr_q <= wbs_adr_i;
                        cnt_q <= '0;
                        if (dec_ok_d) begin
                            stb_q   <= dec_stb_d;
                            cyc_q   <= 1'b1;
                            state_q <= ACCESS;
                        end else begin
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rdat_q  <= 32'hDEAD_BEEF;
                            fadr_q  <= wbs_adr_i;
                            fcnt_q  <= (fcnt_q == 8'hFF) ? fcnt_q : fcnt_q + 8'd1;
                            state_q <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // Master abandoning the cycle takes precedence over everything.
                    if (!wbs_cyc_i) begin
                        stb_q   <= '0;
                        cyc_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (ack_hit) begin
                        stb_q   <= '0;
                        cyc_q   <= 1'b0;
                        ack_q   <= 1'b1;
                        rdat_q  <= we_q ? 32'h0 : rd_mux;
                        state_q <= RESP;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        stb_q   <= '0;
                        cyc_q   <= 1'b0;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        rdat_q  <= 32'hDEAD_BEEF;
                        fadr_q  <= adr_q;
                        fcnt_q  <= (fcnt_q == 8'hFF) ? fcnt_q : fcnt_q + 8'd1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = rdat_q;
    assign slv_stb_o   = stb_q;
    assign slv_cyc_o   = cyc_q;
    assign slv_we_o    = we_q;
    assign slv_sel_o   = sel_q;
    assign slv_dat_o   = dat_q;
    assign slv_adr_o   = {16'h0, adr_q[15:0]};
    assign err_o       = err_q;
    assign fault_cnt_o = fcnt_q;
    assign fault_adr_o = fadr_q;

endmodule

// File: tb/tb_wb_access_sequencer.sv
// Testbench for wb_access_sequencer: directed vector table, rogue-ack/abort/
// reset sequences, randomized transactions against a rule-level model, and
// fault counter saturation.
module tb_wb_access_sequencer;
    localparam int NT = 2;
    localparam int NS = NT + 2;
    localparam int TO = 4;

    logic              wb_clk_i = 1'b0;
    logic              nrst;
    logic              wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_dat_i, wbs_adr_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic [NS-1:0]     slv_stb_o;
    logic              slv_cyc_o, slv_we_o;
    logic [3:0]        slv_sel_o;
    logic [31:0]       slv_dat_o, slv_adr_o;
    logic [NS-1:0]     slv_ack_i;
    logic [32*NS-1:0]  slv_dat_i;
    logic              err_o;
    logic [7:0]        fault_cnt_o;
    logic [31:0]       fault_adr_o;

    wb_access_sequencer #(.NUM_TEAMS(NT), .TIMEOUT(TO)) dut (
        .wb_clk_i(wb_clk_i), .nrst(nrst),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .slv_stb_o(slv_stb_o), .slv_cyc_o(slv_cyc_o), .slv_we_o(slv_we_o),
        .slv_sel_o(slv_sel_o), .slv_dat_o(slv_dat_o), .slv_adr_o(slv_adr_o),
        .slv_ack_i(slv_ack_i), .slv_dat_i(slv_dat_i),
        .err_o(err_o), .fault_cnt_o(fault_cnt_o), .fault_adr_o(fault_adr_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int failures = 0;
    int fcnt_m = 0;
    logic [31:0] sdat [NS];

    typedef struct {
        logic [31:0]   adr;
        logic          we;
        logic [31:0]   wdat;
        int            dly;   // ACCESS cycle index in which the target acks (large = never)
        logic [NS-1:0] rogue; // non-target acks held during ACCESS
        int            lat;
        logic [31:0]   rdat;
        logic          err;
        logic [NS-1:0] stb;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
    endtask

    task automatic load_sdat();
        for (int n = 0; n < NS; n++) slv_dat_i[n*32 +: 32] = sdat[n];
    endtask

    // Reference decode from the address rules: slot number or -1 on error.
    function automatic int exp_slot(input logic [31:0] adr);
        int s;
        if (adr[31:24] != 8'h30) return -1;
        s = int'(adr[23:16]);
        if (s == 0) return 0;
        if (s == 1) return 1;
        if (s >= 17 && s <= 16 + NT) return s - 15;
        return -1;
    endfunction

    // Issue one request (called at a negedge) and check the whole handshake.
    task automatic run_txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] wdat, input int dly, input logic [NS-1:0] rogue,
                           input int exp_lat, input logic [31:0] exp_dat, input logic exp_err,
                           input logic [NS-1:0] exp_stb);
        int acc, lat;
        logic got, er;
        logic [31:0] rd;
        logic [NS-1:0] stb_seen;
        acc = 0; lat = 0; got = 1'b0; er = 1'b0; rd = '0; stb_seen = '0;
        wbs_adr_i = adr; wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = wdat;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; slv_ack_i = '0;
        for (int n = 1; n <= 300 && !got; n++) begin
            step();
            if (wbs_ack_o) begin
                got = 1'b1; lat = n; rd = wbs_dat_o; er = err_o;
                chk("resp_cyc", 32'(slv_cyc_o), 0);
            end else if (slv_cyc_o) begin
                if (acc == 0) begin
                    stb_seen = slv_stb_o;
                    chk("slv_adr", slv_adr_o, {16'h0, adr[15:0]});
                    chk("slv_dat", slv_dat_o, wdat);
                    chk("slv_we_sel", {27'h0, slv_we_o, slv_sel_o}, {27'h0, we, sel});
                end
                slv_ack_i = rogue | ((acc == dly) ? exp_stb : '0);
                acc++;
            end else begin
                slv_ack_i = '0;
            end
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; slv_ack_i = '0;
        chk("ack_seen", 32'(got), 1);
        chk("latency", lat, exp_lat);
        chk("rdata", rd, exp_dat);
        chk("err", 32'(er), 32'(exp_err));
        chk("strobe", 32'(stb_seen), 32'(exp_stb));
        step();
        chk("ack_single", {30'h0, wbs_ack_o, err_o}, 0);
        chk("rdata_hold", wbs_dat_o, exp_dat);
        if (exp_err) begin
            fcnt_m = (fcnt_m == 255) ? 255 : fcnt_m + 1;
            chk("fault_adr", fault_adr_o, adr);
        end
        chk("fault_cnt", 32'(fault_cnt_o), fcnt_m);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {wbs_ack_o, err_o, slv_cyc_o, slv_we_o, slv_sel_o, 28'(slv_stb_o)}, 0);
        chk({nm, "_dat"}, wbs_dat_o | slv_dat_o | slv_adr_o | fault_adr_o, 0);
        chk({nm, "_cnt"}, 32'(fault_cnt_o), 0);
    endtask

    initial begin
        logic [31:0] r, adr;
        logic [7:0]  sub;
        logic        we;
        int          dly, slot, lat;
        logic [NS-1:0] stb, rogue;
        logic [31:0] ed;
        logic        ee;

        nrst = 1'b0; wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
        wbs_dat_i = 0; wbs_adr_i = 0; slv_ack_i = '0; slv_dat_i = '0;

        sdat[0] = 32'h1234_5678; sdat[1] = 32'h1111_1111;
        sdat[2] = 32'h2222_2222; sdat[3] = 32'h3333_3333;
        load_sdat();

        //         adr            we    wdat          dly rogue  lat rdat          err   stb
        tbl[0] = '{32'h3000_0004, 1'b0, 32'h0,          0, 4'b0000, 2, 32'h1234_5678, 1'b0, 4'b0001};
        tbl[1] = '{32'h3011_0010, 1'b1, 32'hA5A5_A5A5,  3, 4'b0000, 5, 32'h0,         1'b0, 4'b0100};
        tbl[2] = '{32'h3002_0000, 1'b0, 32'h0,          0, 4'b0000, 1, 32'hDEAD_BEEF, 1'b1, 4'b0000};
        tbl[3] = '{32'h3001_0000, 1'b0, 32'h0,        999, 4'b0000, 5, 32'hDEAD_BEEF, 1'b1, 4'b0010};
        tbl[4] = '{32'h3001_0008, 1'b0, 32'h0,          3, 4'b0000, 5, 32'h1111_1111, 1'b0, 4'b0010};
        tbl[5] = '{32'h3012_00F0, 1'b0, 32'h0,          1, 4'b0000, 3, 32'h3333_3333, 1'b0, 4'b1000};
        tbl[6] = '{32'h3013_0000, 1'b0, 32'h0,          0, 4'b0000, 1, 32'hDEAD_BEEF, 1'b1, 4'b0000};
        tbl[7] = '{32'h3100_0000, 1'b1, 32'h5,          0, 4'b0000, 1, 32'hDEAD_BEEF, 1'b1, 4'b0000};
        tbl[8] = '{32'h3010_0000, 1'b0, 32'h0,          0, 4'b0000, 1, 32'hDEAD_BEEF, 1'b1, 4'b0000};
        tbl[9] = '{32'h3000_0000, 1'b0, 32'h0,          2, 4'b1010, 4, 32'h1234_5678, 1'b0, 4'b0001};

        // Reset state
        #12;
        chk_all_zero("reset");

        // First request is driven in the same low phase nrst is released.
        @(negedge wb_clk_i);
        nrst = 1'b1;
        for (int i = 0; i < 10; i++)
            run_txn(tbl[i].adr, tbl[i].we, 4'hF, tbl[i].wdat, tbl[i].dly, tbl[i].rogue,
                    tbl[i].lat, tbl[i].rdat, tbl[i].err, tbl[i].stb);

        // Abort: master drops cyc mid-ACCESS; no ack, no fault.
        wbs_adr_i = 32'h3000_0020; wbs_we_i = 0; wbs_sel_i = 4'hF;
        wbs_stb_i = 1; wbs_cyc_i = 1; slv_ack_i = '0;
        step();
        chk("abort_in_access", {31'h0, slv_cyc_o}, 1);
        step();
        wbs_stb_i = 0; wbs_cyc_i = 0;
        step();
        chk("abort_drop", {27'h0, slv_cyc_o, slv_stb_o}, 0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_ack", {30'h0, wbs_ack_o, err_o}, 0);
            step();
        end
        chk("abort_fault_cnt", 32'(fault_cnt_o), fcnt_m);

        // Randomized transactions against the rule-level model.
        for (int i = 0; i < 60; i++) begin
            r = $urandom;
            case ($urandom_range(0, 7))
                0: sub = 8'h00;
                1: sub = 8'h01;
                2: sub = 8'h11;
                3: sub = 8'h12;
                4: sub = 8'h13;
                5: sub = 8'h10;
                6: sub = 8'h02;
                default: sub = r[23:16];
            endcase
            adr = {8'h30, sub, r[15:0]};
            if ($urandom_range(0, 9) == 0) adr = $urandom;
            we  = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, 5);
            for (int n = 0; n < NS; n++) sdat[n] = $urandom;
            load_sdat();
            slot = exp_slot(adr);
            stb  = (slot >= 0) ? (NS'(1) << slot) : '0;
            rogue = NS'($urandom) & ~stb;
            if (slot < 0) begin
                lat = 1; ed = 32'hDEAD_BEEF; ee = 1'b1;
            end else if (dly < TO) begin
                lat = dly + 2; ed = we ? 32'h0 : sdat[slot]; ee = 1'b0;
            end else begin
                lat = TO + 1; ed = 32'hDEAD_BEEF; ee = 1'b1;
            end
            run_txn(adr, we, 4'($urandom), $urandom, dly, rogue, lat, ed, ee, stb);
        end

        // Saturate the fault counter with timeouts.
        for (int i = 0; i < 300; i++)
            run_txn(32'h3001_0000 + 32'(i), 1'b0, 4'h1, 32'h0, 999, '0,
                    TO + 1, 32'hDEAD_BEEF, 1'b1, 4'b0010);
        chk("fault_cnt_sat", 32'(fault_cnt_o), 255);

        // Reset mid-ACCESS clears everything at once.
        wbs_adr_i = 32'h3000_0040; wbs_we_i = 1; wbs_sel_i = 4'h3; wbs_dat_i = 32'hCAFE_F00D;
        wbs_stb_i = 1; wbs_cyc_i = 1; slv_ack_i = '0;
        step();
        chk("midrst_in_access", {31'h0, slv_cyc_o}, 1);
        #1 nrst = 1'b0;
        #1 chk_all_zero("midrst");
        wbs_stb_i = 0; wbs_cyc_i = 0;
        fcnt_m = 0;
        @(negedge wb_clk_i);
        nrst = 1'b1;
        sdat[0] = 32'h0BAD_F00D; load_sdat();
        run_txn(32'h3000_0008, 1'b0, 4'hF, 32'h0, 0, '0, 2, 32'h0BAD_F00D, 1'b0, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
